// File: rtl/dot_product_accumulator.sv
// Sums a stream of unsigned products into one dot-product result per vector and
// hands the result downstream over valid/ready, flagging vector-length mismatches.
module dot_product_accumulator #(
    parameter int VEC_LEN = 8,
    parameter int PROD_W  = 16,
    parameter int ACC_W   = PROD_W + $clog2(VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_last,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [ACC_W-1:0]  sum_data,
    output logic              sum_err
);

    localparam int CNT_W = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VEC_LEN - 1);

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ACC_W-1:0]   sum_data_reg;
    logic               sum_err_reg;

    logic               accept;
    logic               cnt_full;
    logic               final_beat;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc_sum;

    assign accept     = prod_valid && prod_ready;
    assign cnt_full   = (cnt_reg == CNT_MAX);
    assign final_beat = prod_last || cnt_full;
    assign prod_ext   = ACC_W'(prod_data);
    assign acc_sum    = acc_reg + prod_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACC:  if (accept && final_beat) state_next = ST_HOLD;
            ST_HOLD: if (sum_ready)            state_next = ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    // Handshake outputs depend on state only, so sum_ready never reaches prod_ready.
    always_comb begin
        prod_ready = (state_reg == ST_ACC);
        sum_valid  = (state_reg == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg      <= '0;
            cnt_reg      <= '0;
            sum_data_reg <= '0;
            sum_err_reg  <= 1'b0;
        end else if (accept) begin
            if (final_beat) begin
                // Mismatch when last and the length limit do not coincide.
                sum_data_reg <= acc_sum;
                sum_err_reg  <= (prod_last != cnt_full);
                acc_reg      <= '0;
                cnt_reg      <= '0;
            end else begin
                acc_reg <= acc_sum;
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign sum_data = sum_data_reg;
    assign sum_err  = sum_err_reg;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: table vectors, hand-written corner sequences
// and a randomized run against a list-based reference model.
module tb_dot_product_accumulator;

    localparam int VEC_LEN = 8;
    localparam int PROD_W  = 16;
    localparam int ACC_W   = PROD_W + $clog2(VEC_LEN);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              prod_valid = 1'b0;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data = '0;
    logic              prod_last = 1'b0;
    logic              sum_valid;
    logic              sum_ready = 1'b1;
    logic [ACC_W-1:0]  sum_data;
    logic              sum_err;

    int checks = 0;
    int errors = 0;

    dot_product_accumulator #(.VEC_LEN(VEC_LEN), .PROD_W(PROD_W)) dut (
        .clk(clk), .rst(rst),
        .prod_valid(prod_valid), .prod_ready(prod_ready),
        .prod_data(prod_data), .prod_last(prod_last),
        .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum_data(sum_data), .sum_err(sum_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          first;
        int          step;
        int          nbeats;
        bit          has_last;
        logic [31:0] exp_sum;
        bit          exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic send_beat(input logic [PROD_W-1:0] d, input logic l);
        int waitc = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = l;
        while (!prod_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        if (!prod_ready) check("beat_accept_timeout", {31'd0, prod_ready}, 32'd1);
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned q[$];
        longint      exp_sum;
        bit          exp_err;
        bit          busy;
        int          acc_cnt;
        int          cyc;
        bit          acc_now;

        tbl[0] = '{32'hFE01, 0, 8, 1'b1, 32'h7F008, 1'b0};
        tbl[1] = '{1, 1, 8, 1'b1, 32'd36, 1'b0};
        tbl[2] = '{10, 10, 3, 1'b1, 32'd60, 1'b1};
        tbl[3] = '{1, 0, 8, 1'b1, 32'd8, 1'b0};
        tbl[4] = '{2, 0, 8, 1'b0, 32'd16, 1'b1};
        tbl[5] = '{1, 0, 8, 1'b1, 32'd8, 1'b0};

        // Reset state
        tick();
        do_reset();
        check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        check("rst_sum_data", 32'(sum_data), 32'd0);
        check("rst_sum_err", {31'd0, sum_err}, 32'd0);
        check("rst_prod_ready", {31'd0, prod_ready}, 32'd1);

        // Table vectors with sum_ready held high
        sum_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < tbl[i].nbeats; b++) begin
                send_beat(PROD_W'(tbl[i].first + b * tbl[i].step),
                          tbl[i].has_last && (b == tbl[i].nbeats - 1));
                if (b < tbl[i].nbeats - 1)
                    check($sformatf("tbl%0d_early_valid", i), {31'd0, sum_valid}, 32'd0);
            end
            check($sformatf("tbl%0d_sum_valid", i), {31'd0, sum_valid}, 32'd1);
            check($sformatf("tbl%0d_sum_data", i), 32'(sum_data), tbl[i].exp_sum);
            check($sformatf("tbl%0d_sum_err", i), {31'd0, sum_err}, {31'd0, tbl[i].exp_err});
            check($sformatf("tbl%0d_ready_low", i), {31'd0, prod_ready}, 32'd0);
            tick();
            check($sformatf("tbl%0d_valid_drop", i), {31'd0, sum_valid}, 32'd0);
            check($sformatf("tbl%0d_ready_back", i), {31'd0, prod_ready}, 32'd1);
        end

        // Backpressure: result held for 5 cycles
        sum_ready = 1'b0;
        for (int b = 1; b <= 8; b++) send_beat(PROD_W'(b), b == 8);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid_c%0d", c), {31'd0, sum_valid}, 32'd1);
            check($sformatf("bp_data_c%0d", c), 32'(sum_data), 32'd36);
            check($sformatf("bp_ready_c%0d", c), {31'd0, prod_ready}, 32'd0);
            if (c < 4) tick();
        end
        sum_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, sum_valid}, 32'd0);
        check("bp_release_ready", {31'd0, prod_ready}, 32'd1);

        // Reset mid-accumulation discards partial sum
        for (int b = 0; b < 4; b++) send_beat(PROD_W'(100), 1'b0);
        do_reset();
        check("rstmid_ready", {31'd0, prod_ready}, 32'd1);
        for (int b = 0; b < 8; b++) send_beat(PROD_W'(5), b == 7);
        check("rstmid_valid", {31'd0, sum_valid}, 32'd1);
        check("rstmid_sum", 32'(sum_data), 32'd40);
        check("rstmid_err", {31'd0, sum_err}, 32'd0);
        tick();

        // Reset while holding a result
        sum_ready = 1'b0;
        for (int b = 0; b < 8; b++) send_beat(PROD_W'(1), b == 7);
        check("rsthold_pre_valid", {31'd0, sum_valid}, 32'd1);
        do_reset();
        check("rsthold_valid", {31'd0, sum_valid}, 32'd0);
        check("rsthold_data", 32'(sum_data), 32'd0);
        check("rsthold_ready", {31'd0, prod_ready}, 32'd1);
        sum_ready = 1'b1;

        // Gapped input
        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < 8 && cyc < 300) begin
            prod_valid = ($urandom_range(0, 1) == 1);
            prod_data  = PROD_W'(3);
            prod_last  = (acc_cnt == 7);
            acc_now    = prod_valid && prod_ready;
            tick();
            cyc++;
            if (acc_now) acc_cnt++;
            if (acc_cnt < 8) check("gap_no_early_result", {31'd0, sum_valid}, 32'd0);
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        check("gap_accepts", 32'(acc_cnt), 32'd8);
        check("gap_valid", {31'd0, sum_valid}, 32'd1);
        check("gap_sum", 32'(sum_data), 32'd24);
        check("gap_err", {31'd0, sum_err}, 32'd0);
        tick();

        // Randomized run against a reference model built on a list of accepted beats
        do_reset();
        q.delete();
        busy = 1'b0;
        exp_sum = 0;
        exp_err = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            check("rnd_prod_ready", {31'd0, prod_ready}, {31'd0, !busy});
            check("rnd_sum_valid", {31'd0, sum_valid}, {31'd0, busy});
            if (busy) begin
                check("rnd_sum_data", 32'(sum_data), 32'(exp_sum));
                check("rnd_sum_err", {31'd0, sum_err}, {31'd0, exp_err});
            end
            prod_valid = ($urandom_range(0, 3) != 0);
            prod_data  = PROD_W'($urandom_range(0, 65535));
            prod_last  = ($urandom_range(0, 5) == 0);
            sum_ready  = ($urandom_range(0, 2) != 0);
            if (!busy && prod_valid) begin
                q.push_back(int'(prod_data));
                if (prod_last || q.size() == VEC_LEN) begin
                    exp_sum = 0;
                    foreach (q[k]) exp_sum += q[k];
                    exp_err = (prod_last != (q.size() == VEC_LEN));
                    busy = 1'b1;
                    q.delete();
                end
            end else if (busy && sum_ready) begin
                busy = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
